// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: rebuilds LSB-first data words from a bit stream.
// Ports: clk, rst (sync, active-high); i_x/i_valid/i_sof in;
//   o_data/o_valid/o_parity_err/o_abort/o_err_cnt/o_busy out.
module parity_frame_checker #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = 1,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_x,
  input  logic                 i_valid,
  input  logic                 i_sof,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_abort,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic                 o_busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  localparam logic ODD = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   abort_q, abort_d;
  logic [ERR_CNT_W-1:0]   errcnt_q, errcnt_d;

  logic start;
  logic bit_in;
  logic err;

  assign start  = i_valid & i_sof;
  assign bit_in = i_valid & ~i_sof;
  assign err    = ((par_q ^ i_x) != ODD);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    perr_d   = perr_q;
    abort_d  = 1'b0;
    errcnt_d = errcnt_q;

    unique case (1'b1)
      start: begin
        abort_d = (state_q != IDLE);
        // Right shift: after DATA_W bits, the first bit lands in bit 0.
        shreg_d = {i_x, {(DATA_W-1){1'b0}}};
        par_d   = i_x;
        cnt_d   = CNT_W'(1);
        state_d = (DATA_W == 1) ? PAR : DATA;
      end
      bit_in: begin
        unique case (state_q)
          IDLE: ;
          DATA: begin
            shreg_d = {i_x, shreg_q[DATA_W-1:1]};
            par_d   = par_q ^ i_x;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = PAR;
          end
          PAR: begin
            valid_d = 1'b1;
            data_d  = shreg_q;
            perr_d  = err;
            if (err && (errcnt_q != {ERR_CNT_W{1'b1}}))
              errcnt_d = errcnt_q + 1'b1;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      abort_q  <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      abort_q  <= abort_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_abort      = abort_q;
  assign o_err_cnt    = errcnt_q;
  assign o_busy       = (state_q != IDLE);

endmodule
